interface_hcsr04_multi: RTL and testbench

//  Multi-channel controller plus datapath for HC-SR04 ultrasonic sensors.
//  - Scans N_CH sensors in sequence: trigger pulse, echo-width measurement in cm, timeout detection.
//  - Emits one result per channel with a single-cycle pronto strobe.
//  - Supports one-shot sweep or continuous mode.
//  - Sits between the top-level measurement FSM and the display/serial path.
//  - Replaces the single-sensor interface UC and datapath pair.

---
 rtl/interface_hcsr04_multi.sv | 182 ++++++++++++++++++
 tb/tb_interface_hcsr04_multi.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interface_hcsr04_multi.sv
// Multi-channel HC-SR04 controller and datapath: sequential trigger/echo scan with cm conversion and timeout.
// Optional per-channel 2-sample averaging is enabled by defining HCSR04_MEDIA_EN.
module interface_hcsr04_multi #(
    parameter int N_CH        = 4,
    parameter int DIST_W      = 12,
    parameter int TRIG_CYC    = 500,
    parameter int CM_CYC      = 2941,
    parameter int TIMEOUT_CYC = 1_500_000,
    parameter int GAP_CYC     = 3_000_000,
    localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              medir,
    input  logic              continuo,
    input  logic [N_CH-1:0]   echo,
    output logic [N_CH-1:0]   trigger,
    output logic [DIST_W-1:0] distancia,
    output logic [CW-1:0]     canal,
    output logic              erro,
    output logic              pronto,
    output logic              ocupado,
    output logic [3:0]        db_estado
);

    localparam int CYC_MAX = (TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int SUB_W   = (CM_CYC > 1) ? $clog2(CM_CYC) : 1;
    localparam logic [DIST_W-1:0] CM_MAX = {{(DIST_W-1){1'b1}}, 1'b0};

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        TRIGGER     = 4'h2,
        ESPERA_ECHO = 4'h3,
        MEDIDA      = 4'h4,
        ARMAZENA    = 4'h5,
        INTERVALO   = 4'h6,
        FINAL       = 4'hF
    } state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     ch;
    logic [N_CH-1:0]   echo_meta, echo_sync;
    logic              echo_last;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [SUB_W-1:0]  sub_cnt;
    logic [DIST_W-1:0] cm_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              to_flag;
    logic [DIST_W-1:0] dist_new;

    logic echo_sel, rise, trig_done, gap_done, ch_last, waiting, timeout_hit, count_en;

    assign echo_sel    = echo_sync[ch];
    assign rise        = echo_sel & ~echo_last;
    assign trig_done   = (cyc_cnt == CYC_W'(TRIG_CYC - 1));
    assign gap_done    = (cyc_cnt == CYC_W'(GAP_CYC - 1));
    assign ch_last     = (ch == CW'(N_CH - 1));
    assign waiting     = (state == ESPERA_ECHO) || (state == MEDIDA);
    assign timeout_hit = waiting && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    // The cycle that reveals the rising edge is already part of the echo width.
    assign count_en    = !timeout_hit &&
                         (((state == ESPERA_ECHO) && rise) || ((state == MEDIDA) && echo_sel));

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            INICIAL:     if (medir) state_nx = PREPARA;
            PREPARA:     state_nx = TRIGGER;
            TRIGGER:     if (trig_done) state_nx = ESPERA_ECHO;
            ESPERA_ECHO: if (timeout_hit) state_nx = ARMAZENA;
                         else if (rise) state_nx = MEDIDA;
            MEDIDA:      if (timeout_hit || !echo_sel) state_nx = ARMAZENA;
            ARMAZENA:    state_nx = FINAL;
            FINAL:       state_nx = (!ch_last || continuo) ? INTERVALO : INICIAL;
            INTERVALO:   if (gap_done) state_nx = PREPARA;
            default:     state_nx = INICIAL;
        endcase
    end

    always_comb begin
        trigger = '0;
        if (state == TRIGGER) trigger[ch] = 1'b1;
    end

    assign pronto  = (state == FINAL);
    assign ocupado = (state != INICIAL);

    always_comb begin
        case (state)
            INICIAL, PREPARA, TRIGGER, ESPERA_ECHO, MEDIDA, ARMAZENA, INTERVALO, FINAL:
                db_estado = state;
            default: db_estado = 4'hE;
        endcase
    end

`ifdef HCSR04_MEDIA_EN
    logic [DIST_W-1:0] hist [N_CH];
    logic [N_CH-1:0]   hist_v;
    logic [DIST_W:0]   avg_sum;

    always_comb begin
        avg_sum  = {1'b0, cm_cnt} + {1'b0, hist[ch]};
        dist_new = hist_v[ch] ? avg_sum[DIST_W:1] : cm_cnt;
    end

    // NOTE: the history payload is left unreset; hist_v marks which entries hold real data.
    always_ff @(posedge clock) begin
        if (state == ARMAZENA && !to_flag) hist[ch] <= cm_cnt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) hist_v <= '0;
        else if (state == ARMAZENA && !to_flag) hist_v[ch] <= 1'b1;
    end
`else
    always_comb dist_new = cm_cnt;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= INICIAL;
            ch        <= '0;
            echo_meta <= '0;
            echo_sync <= '0;
            echo_last <= 1'b0;
            cyc_cnt   <= '0;
            sub_cnt   <= '0;
            cm_cnt    <= '0;
            to_cnt    <= '0;
            to_flag   <= 1'b0;
            distancia <= '0;
            canal     <= '0;
            erro      <= 1'b0;
        end else begin
            state     <= state_nx;
            echo_meta <= echo;
            echo_sync <= echo_meta;
            echo_last <= echo_sel;

            if ((state == TRIGGER && !trig_done) || (state == INTERVALO && !gap_done))
                cyc_cnt <= cyc_cnt + 1'b1;
            else
                cyc_cnt <= '0;

            if (state == PREPARA) begin
                sub_cnt <= '0;
                cm_cnt  <= '0;
                to_cnt  <= '0;
                to_flag <= 1'b0;
            end else if (waiting) begin
                to_cnt <= to_cnt + 1'b1;
                if (timeout_hit) to_flag <= 1'b1;
            end

            if (count_en) begin
                if (sub_cnt == SUB_W'(CM_CYC - 1)) begin
                    sub_cnt <= '0;
                    if (cm_cnt != CM_MAX) cm_cnt <= cm_cnt + 1'b1;
                end else begin
                    sub_cnt <= sub_cnt + 1'b1;
                end
            end

            if (state == ARMAZENA) begin
                distancia <= to_flag ? '1 : dist_new;
                canal     <= ch;
                erro      <= to_flag;
            end

            if (state == INICIAL)
                ch <= '0;
            else if (state == INTERVALO && gap_done)
                ch <= ch_last ? '0 : ch + 1'b1;
        end
    end

endmodule

// File: tb/tb_interface_hcsr04_multi.sv
// Self-checking bench for interface_hcsr04_multi: directed sweeps plus random echo widths
// compared against a distance model built from the cm/timeout/averaging rules.
module tb_interface_hcsr04_multi;

    localparam int N_CH        = 2;
    localparam int DIST_W      = 6;
    localparam int TRIG_CYC    = 10;
    localparam int CM_CYC      = 5;
    localparam int TIMEOUT_CYC = 1000;
    localparam int GAP_CYC     = 20;
    localparam int CW          = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DMAX        = (1 << DIST_W) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              medir;
    logic              continuo;
    logic [N_CH-1:0]   echo;
    logic [N_CH-1:0]   trigger;
    logic [DIST_W-1:0] distancia;
    logic [CW-1:0]     canal;
    logic              erro;
    logic              pronto;
    logic              ocupado;
    logic [3:0]        db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    interface_hcsr04_multi #(
        .N_CH(N_CH), .DIST_W(DIST_W), .TRIG_CYC(TRIG_CYC), .CM_CYC(CM_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .clock(clock), .reset(reset), .medir(medir), .continuo(continuo), .echo(echo),
        .trigger(trigger), .distancia(distancia), .canal(canal), .erro(erro),
        .pronto(pronto), .ocupado(ocupado), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef HCSR04_MEDIA_EN
    int hist   [N_CH];
    bit hist_v [N_CH];
`endif

    task automatic model_reset();
`ifdef HCSR04_MEDIA_EN
        for (int i = 0; i < N_CH; i++) begin
            hist[i]   = 0;
            hist_v[i] = 0;
        end
`endif
    endtask

    // width < 0 stands for "echo never arrives".
    function automatic int model_result(input int ch, input int width);
        int raw;
        int res;
        if (width < 0) return DMAX;
        raw = width / CM_CYC;
        if (raw > DMAX - 1) raw = DMAX - 1;
        res = raw;
`ifdef HCSR04_MEDIA_EN
        if (hist_v[ch]) res = (raw + hist[ch]) / 2;
        hist[ch]   = raw;
        hist_v[ch] = 1;
`else
        if (ch < 0) res = 0;
`endif
        return res;
    endfunction

    task automatic pulse_medir();
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_estado"}, db_estado, 4'h0);
        check({tag, "_ocupado"}, ocupado, 1'b0);
        check({tag, "_trigger"}, trigger, '0);
    endtask

    task automatic do_channel(input int ch, input int width, input bit toggle_other,
                              input bit clr_cont, output int waited);
        logic [N_CH-1:0] oh;
        int len, lat, d, exp_d, other;
        oh = '0;
        oh[ch] = 1'b1;
        other = (ch + 1) % N_CH;
        waited = 0;
        while (trigger == '0 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        check($sformatf("ch%0d_trig_sel", ch), trigger, oh);
        check($sformatf("ch%0d_trig_estado", ch), db_estado, 4'h2);
        len = 0;
        while (trigger == oh && len < 100) begin
            @(negedge clock);
            len++;
        end
        check($sformatf("ch%0d_trig_len", ch), len, TRIG_CYC);
        check($sformatf("ch%0d_espera_estado", ch), db_estado, 4'h3);
        if (clr_cont) continuo = 1'b0;
        exp_d = model_result(ch, width);
        lat = 0;
        if (width < 0) begin
            while (!pronto && lat < TIMEOUT_CYC + 100) begin
                @(negedge clock);
                lat++;
            end
            check($sformatf("ch%0d_timeout_lat %0d", ch, lat),
                  (lat >= TIMEOUT_CYC && lat <= TIMEOUT_CYC + 2), 1'b1);
        end else begin
            d = $urandom_range(1, 10);
            repeat (d) @(negedge clock);
            echo[ch] = 1'b1;
            repeat (width) begin
                @(negedge clock);
                if (toggle_other) echo[other] = ~echo[other];
            end
            echo = '0;
            while (!pronto && lat < 50) begin
                @(negedge clock);
                lat++;
            end
            check($sformatf("ch%0d_fall_lat w=%0d", ch, width), lat, 4);
        end
        check($sformatf("ch%0d_pronto", ch), pronto, 1'b1);
        check($sformatf("ch%0d_final_estado", ch), db_estado, 4'hF);
        check($sformatf("ch%0d_dist w=%0d", ch, width), distancia, exp_d);
        check($sformatf("ch%0d_canal", ch), canal, ch);
        check($sformatf("ch%0d_erro", ch), erro, (width < 0));
        @(negedge clock);
        check($sformatf("ch%0d_pronto_1cyc", ch), pronto, 1'b0);
    endtask

    task automatic check_gap(input string tag, input int waited);
        check({tag, "_gap"}, (waited + 1 >= GAP_CYC && waited + 1 <= GAP_CYC + 2), 1'b1);
    endtask

    initial begin
        int w;
        int wd;
        reset    = 1'b0;
        medir    = 1'b0;
        continuo = 1'b0;
        echo     = '0;
        model_reset();
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_trigger", trigger, '0);
        check("rst_distancia", distancia, '0);
        check("rst_canal", canal, '0);
        check("rst_erro", erro, 1'b0);
        check("rst_pronto", pronto, 1'b0);
        check("rst_ocupado", ocupado, 1'b0);
        check("rst_estado", db_estado, 4'h0);
        reset = 1'b1;
        repeat (50) @(negedge clock);
        check_idle("idle50");
        check("idle50_pronto", pronto, 1'b0);

        // Normal ch0 reading, then ch1 timeout
        pulse_medir();
        do_channel(0, 52, 1'b0, 1'b0, w);
        do_channel(1, -1, 1'b0, 1'b0, w);
        check_gap("t2", w);
        check_idle("t3_end");

        // Saturation with echo[1] activity during ch0
        pulse_medir();
        do_channel(0, 400, 1'b1, 1'b0, w);
        do_channel(1, $urandom_range(1, 300), 1'b0, 1'b0, w);
        check_gap("t4", w);
        check_idle("t4_end");

        // Continuous mode, then drop continuo during ch0
        continuo = 1'b1;
        pulse_medir();
        do_channel(0, $urandom_range(1, 300), 1'b0, 1'b0, w);
        do_channel(1, $urandom_range(1, 300), 1'b0, 1'b0, w);
        check_gap("t5a", w);
        do_channel(0, $urandom_range(1, 300), 1'b0, 1'b1, w);
        check_gap("t5_wrap", w);
        do_channel(1, $urandom_range(1, 300), 1'b0, 1'b0, w);
        check_gap("t5b", w);
        check_idle("t5_end");

        // Reset mid-TRIGGER
        pulse_medir();
        wd = 0;
        while (trigger == '0 && wd < 200) begin
            @(negedge clock);
            wd++;
        end
        repeat (3) @(negedge clock);
        check("t5_trig_before_rst", trigger, 2'b01);
        reset = 1'b0;
        #1;
        check("t5_rst_trigger", trigger, '0);
        check("t5_rst_estado", db_estado, 4'h0);
        check("t5_rst_ocupado", ocupado, 1'b0);
        check("t5_rst_pronto", pronto, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_reset();
        repeat (30) @(negedge clock);
        check_idle("t5_after_rst");
        check("t5_after_rst_dist", distancia, '0);

        // History sequence: 50, timeout, 100 on ch0
        pulse_medir();
        do_channel(0, 50, 1'b0, 1'b0, w);
        do_channel(1, $urandom_range(1, 300), 1'b0, 1'b0, w);
        pulse_medir();
        do_channel(0, -1, 1'b0, 1'b0, w);
        do_channel(1, $urandom_range(1, 300), 1'b0, 1'b0, w);
        pulse_medir();
        do_channel(0, 100, 1'b0, 1'b0, w);
        do_channel(1, $urandom_range(1, 300), 1'b0, 1'b0, w);
        check_idle("t6_end");

        // Random sweeps
        for (int s = 0; s < 4; s++) begin
            pulse_medir();
            for (int c = 0; c < N_CH; c++) begin
                int wr;
                wr = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 400));
                do_channel(c, wr, 1'b0, 1'b0, w);
            end
            check_idle($sformatf("rand%0d_end", s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
